// File: rtl/mem_delayed_pipelined.sv
// Pipelined delayed-response memory model: one request per cycle, in-order
// completion exactly LATENCY edges after acceptance, byte-enabled writes.
module mem_delayed_pipelined #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 8,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_req,
  input  logic                    wr_req,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic                    busy,
  output logic                    ack,
  output logic                    ack_wr,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic [LATENCY-1:0]    vld_p;
  logic                  wr_p   [LATENCY];
  logic [ADDR_WIDTH-1:0] addr_p [LATENCY];
  logic [DATA_WIDTH-1:0] data_p [LATENCY];
  logic [BE_W-1:0]       be_p   [LATENCY];

  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             retire;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_W-1:0]       be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  // busy comes straight from the registered count, so a freed slot is
  // usable only from the edge after the retire.
  assign busy   = (cnt == CNT_W'(MAX_OUTSTANDING));
  assign accept = (rd_req | wr_req) & ~busy;
  assign retire = vld_p[LATENCY-1];

  // Control: valid chain, in-flight count, registered completion outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p   <= '0;
      cnt     <= '0;
      ack     <= 1'b0;
      ack_wr  <= 1'b0;
      rd_data <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
      if (accept && !retire)      cnt <= cnt + CNT_W'(1);
      else if (!accept && retire) cnt <= cnt - CNT_W'(1);
      ack <= retire;
      if (retire) begin
        ack_wr <= wr_p[LATENCY-1];
        if (!wr_p[LATENCY-1]) rd_data <= mem[addr_p[LATENCY-1]];
      end
    end
  end

  // Data: request payload shifts alongside vld_p; a dual request counts as a write
  always_ff @(posedge clk) begin
    wr_p[0]   <= wr_req;
    addr_p[0] <= addr;
    data_p[0] <= wr_data;
    be_p[0]   <= byte_en;
    for (int i = 1; i < LATENCY; i++) begin
      wr_p[i]   <= wr_p[i-1];
      addr_p[i] <= addr_p[i-1];
      data_p[i] <= data_p[i-1];
      be_p[i]   <= be_p[i-1];
    end
  end

  // Memory commit at retire; a reset edge suppresses any retiring write
  always_ff @(posedge clk) begin
    if (rst_n && retire && wr_p[LATENCY-1]) begin
      mem[addr_p[LATENCY-1]] <= merge_bytes(mem[addr_p[LATENCY-1]],
                                            data_p[LATENCY-1], be_p[LATENCY-1]);
    end
  end

endmodule

// File: tb/tb_mem_delayed_pipelined.sv
// Directed self-checking bench for mem_delayed_pipelined at LATENCY=4,
// MAX_OUTSTANDING=4.
module tb_mem_delayed_pipelined;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_req = 1'b0;
  logic        wr_req = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  byte_en = '0;
  logic        busy;
  logic        ack;
  logic        ack_wr;
  logic [31:0] rd_data;

  int checks = 0;
  int failures = 0;

  mem_delayed_pipelined #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .LATENCY(4), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .wr_req(wr_req),
    .addr(addr), .wr_data(wr_data), .byte_en(byte_en),
    .busy(busy), .ack(ack), .ack_wr(ack_wr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit rd, input bit wr, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    rd_req = rd; wr_req = wr; addr = a; wr_data = d; byte_en = be;
  endtask

  task automatic clear_req();
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_req();
    step();
    step();
    checks++;
    if (ack !== 1'b0 || ack_wr !== 1'b0 || busy !== 1'b0 || rd_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: ack=%b ack_wr=%b busy=%b rd_data=%h required 0 0 0 00000000",
               ack, ack_wr, busy, rd_data);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    set_req(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    step();
    clear_req();
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (ack !== (k == 4)) begin
        failures++;
        $display("FAIL basic_wr_ack edge=%0d: ack=%b required %b", k, ack, (k == 4));
      end
    end
    checks++;
    if (ack_wr !== 1'b1) begin
      failures++;
      $display("FAIL basic_wr_type: ack_wr=%b required 1", ack_wr);
    end
    set_req(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    step();
    clear_req();
    for (int k = 6; k <= 9; k++) begin
      step();
      checks++;
      if (ack !== (k == 9)) begin
        failures++;
        $display("FAIL basic_rd_ack edge=%0d: ack=%b required %b", k, ack, (k == 9));
      end
    end
    checks++;
    if (ack_wr !== 1'b0 || rd_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_rd_data: ack_wr=%b rd_data=%h required 0 deadbeef", ack_wr, rd_data);
    end
  endtask

  task automatic test_byte_en();
    bit got;
    set_req(1'b0, 1'b1, 8'h20, 32'h11223344, 4'hF);
    step(); clear_req(); wait_ack(got);
    set_req(1'b0, 1'b1, 8'h20, 32'hAABBCCDD, 4'b0101);
    step(); clear_req(); wait_ack(got);
    set_req(1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
    step(); clear_req(); wait_ack(got);
    checks++;
    if (!got || ack_wr !== 1'b0 || rd_data !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL byte_en: got=%b ack_wr=%b rd_data=%h required 1 0 11bb33dd", got, ack_wr, rd_data);
    end
  endtask

  task automatic test_backpressure();
    bit got;
    logic [31:0] vals [6];
    logic [7:0]  e_addr [7];
    logic        e_busy [7];
    int          ack_n;
    vals   = '{32'hA0A0_0000, 32'hA1A1_0001, 32'hA2A2_0002,
               32'hA3A3_0003, 32'hA4A4_0004, 32'hA5A5_0005};
    e_addr = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h44, 8'h45};
    e_busy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      set_req(1'b0, 1'b1, 8'h40 + 8'(i), vals[i], 4'hF);
      step(); clear_req(); wait_ack(got);
    end
    ack_n = 0;
    for (int e = 0; e <= 14; e++) begin
      if (e <= 6) set_req(1'b1, 1'b0, e_addr[e], 32'h0, 4'h0);
      else clear_req();
      step();
      if (e <= 6) begin
        checks++;
        if (busy !== e_busy[e]) begin
          failures++;
          $display("FAIL bp_busy edge=%0d: busy=%b required %b", e, busy, e_busy[e]);
        end
      end
      checks++;
      if (ack !== (e inside {4, 5, 6, 7, 9, 10})) begin
        failures++;
        $display("FAIL bp_ack edge=%0d: ack=%b required %b", e, ack, (e inside {4, 5, 6, 7, 9, 10}));
      end
      if (ack && ack_n < 6) begin
        checks++;
        if (rd_data !== vals[ack_n] || ack_wr !== 1'b0) begin
          failures++;
          $display("FAIL bp_order ack#%0d: rd_data=%h ack_wr=%b required %h 0",
                   ack_n, rd_data, ack_wr, vals[ack_n]);
        end
        ack_n++;
      end
    end
    clear_req();
  endtask

  task automatic test_raw();
    set_req(1'b0, 1'b1, 8'h03, 32'h55, 4'hF);
    step();
    set_req(1'b1, 1'b0, 8'h03, 32'h0, 4'h0);
    step();
    clear_req();
    for (int e = 2; e <= 6; e++) begin
      step();
      checks++;
      if (ack !== (e == 4 || e == 5)) begin
        failures++;
        $display("FAIL raw_ack edge=%0d: ack=%b required %b", e, ack, (e == 4 || e == 5));
      end
      if (e == 4) begin
        checks++;
        if (ack_wr !== 1'b1) begin
          failures++;
          $display("FAIL raw_wr_type: ack_wr=%b required 1", ack_wr);
        end
      end
      if (e == 5) begin
        checks++;
        if (ack_wr !== 1'b0 || rd_data !== 32'h55) begin
          failures++;
          $display("FAIL raw_rd_data: ack_wr=%b rd_data=%h required 0 00000055", ack_wr, rd_data);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    bit got;
    int n_ack;
    set_req(1'b0, 1'b1, 8'h07, 32'h1, 4'hF);
    step(); clear_req(); wait_ack(got);
    set_req(1'b0, 1'b1, 8'h07, 32'h2, 4'hF);
    step();
    clear_req();
    step();
    rst_n = 1'b0;
    set_req(1'b0, 1'b1, 8'h07, 32'h3, 4'hF);
    step();
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || rd_data !== 32'h0) begin
      failures++;
      $display("FAIL midrst_state: ack=%b busy=%b rd_data=%h required 0 0 00000000", ack, busy, rd_data);
    end
    clear_req();
    rst_n = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ack) n_ack++;
    end
    checks++;
    if (n_ack !== 0) begin
      failures++;
      $display("FAIL midrst_no_ack: acks=%0d required 0", n_ack);
    end
    set_req(1'b1, 1'b0, 8'h07, 32'h0, 4'h0);
    step(); clear_req(); wait_ack(got);
    checks++;
    if (!got || rd_data !== 32'h1) begin
      failures++;
      $display("FAIL midrst_mem: got=%b rd_data=%h required 1 00000001", got, rd_data);
    end
  endtask

  task automatic test_simultaneous();
    bit got;
    int n_ack;
    logic wr_seen;
    set_req(1'b1, 1'b1, 8'h30, 32'hCAFE0001, 4'hF);
    step();
    clear_req();
    n_ack = 0;
    wr_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ack) begin
        n_ack++;
        wr_seen = ack_wr;
      end
    end
    checks++;
    if (n_ack !== 1 || wr_seen !== 1'b1) begin
      failures++;
      $display("FAIL simul_ack: acks=%0d ack_wr=%b required 1 1", n_ack, wr_seen);
    end
    set_req(1'b1, 1'b0, 8'h30, 32'h0, 4'h0);
    step(); clear_req(); wait_ack(got);
    checks++;
    if (!got || rd_data !== 32'hCAFE0001) begin
      failures++;
      $display("FAIL simul_mem: got=%b rd_data=%h required 1 cafe0001", got, rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_en();
    test_backpressure();
    test_raw();
    test_reset_midflight();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
